// File: rtl/sap_ram.sv
// SAP main memory: registered-address word array with programmable wait states and busy/done handshake.
// Optional out-of-range detection with sticky err is enabled by defining SAP_RAM_RANGE_CHECK_EN.
module sap_ram #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] bus_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [15:0]       mem [DEPTH];
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [15:0]       dat_q;
  logic              op_wr;
  logic              oor_q;
  logic              oor_in;
  logic              req;

  assign req = mem_write | mem_read;

`ifdef SAP_RAM_RANGE_CHECK_EN
  assign oor_in = ((32'(addr) >> ADDR_W) != 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state == S_IDLE && req && oor_in) begin
      err <= 1'b1;
    end
  end
`else
  // Upper address bits are intentionally dropped: indexing wraps by truncation.
  logic unused_addr;
  assign unused_addr = ^addr;
  assign oor_in      = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      bus_out <= 16'h0000;
      idx_q   <= '0;
      dat_q   <= 16'h0000;
      op_wr   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            op_wr <= mem_write;
            idx_q <= addr[ADDR_W-1:0];
            dat_q <= bus_in;
            oor_q <= oor_in;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!op_wr) begin
            bus_out <= oor_q ? 16'hFFFF : mem[idx_q];
          end
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Commit only happens on the ACCESS exit edge, so a reset before it drops the write.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && op_wr && !oor_q) begin
      mem[idx_q] <= dat_q;
    end
  end

  assign busy   = (state == S_WAIT) || (state == S_ACCESS);
  assign done   = (state == S_DONE);
  assign bus_oe = (state == S_DONE) && !op_wr;

endmodule

// File: tb/tb_sap_ram.sv
// Directed self-checking bench for sap_ram with hand-computed expected values.
module tb_sap_ram;

  localparam int WS = 2;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] bus_in;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int failures;

  sap_ram #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .bus_in    (bus_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; operands are scrambled right after acceptance.
  task automatic xfer(input string tag, input logic wr, input logic rd,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic poke, input logic chk_rd, input logic [15:0] exp_rd,
                      output logic err_acc);
    int bad;
    int extra;
    mem_write = wr;
    mem_read  = rd;
    addr      = a;
    bus_in    = d;
    tick();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    addr      = 16'hFFFF;
    bus_in    = 16'h0000;
    err_acc   = err;
    bad = 0;
    for (int k = 0; k < WS + 1; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || bus_oe !== 1'b0) bad++;
      if (poke && k == 0) mem_read = 1'b1;
      tick();
      mem_read = 1'b0;
    end
    chk({tag, "_busy_window"}, bad, 0);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 0);
    chk({tag, "_oe"}, {31'd0, bus_oe}, {31'd0, rd && !wr});
    if (chk_rd) chk({tag, "_data"}, {16'd0, bus_out}, {16'd0, exp_rd});
    tick();
    chk({tag, "_idle"}, {29'd0, busy, done, bus_oe}, 0);
    if (poke) begin
      extra = 0;
      for (int k = 0; k < WS + 4; k++) begin
        if (done === 1'b1) extra++;
        tick();
      end
      chk({tag, "_no_second_done"}, extra, 0);
    end
  endtask

  logic ea;
  int   dcnt;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    addr      = 16'h0000;
    bus_in    = 16'h0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {12'd0, busy, done, bus_oe, err, bus_out}, 0);
    rst = 1'b1;
    tick();

    xfer("pre_ff", 1'b1, 1'b0, 16'h00FF, 16'h1111, 1'b0, 1'b0, 16'h0000, ea);
    xfer("wr_beef", 1'b1, 1'b0, 16'h0012, 16'hBEEF, 1'b0, 1'b0, 16'h0000, ea);
    xfer("rd_beef", 1'b0, 1'b1, 16'h0012, 16'h0000, 1'b0, 1'b1, 16'hBEEF, ea);
    chk("bus_out_hold", {16'd0, bus_out}, 32'h0000BEEF);

    xfer("prio_wr", 1'b1, 1'b1, 16'h0005, 16'h1234, 1'b1, 1'b0, 16'h0000, ea);
    chk("prio_keeps_bus_out", {16'd0, bus_out}, 32'h0000BEEF);
    xfer("rd_5", 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234, ea);

    xfer("wr_a5a5", 1'b1, 1'b0, 16'h0003, 16'hA5A5, 1'b0, 1'b0, 16'h0000, ea);
    xfer("rd_3", 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'hA5A5, ea);
    xfer("rd_ff", 1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h1111, ea);
    xfer("rd_12_again", 1'b0, 1'b1, 16'h0012, 16'h0000, 1'b0, 1'b1, 16'hBEEF, ea);

`ifdef SAP_RAM_RANGE_CHECK_EN
    chk("err_before_oor", {31'd0, err}, 0);
    xfer("oor_wr", 1'b1, 1'b0, 16'h0105, 16'h5555, 1'b0, 1'b0, 16'h0000, ea);
    chk("err_at_accept", {31'd0, ea}, 1);
    xfer("rd_5_unchanged", 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234, ea);
    xfer("oor_rd", 1'b0, 1'b1, 16'h0105, 16'h0000, 1'b0, 1'b1, 16'hFFFF, ea);
    chk("err_sticky", {31'd0, err}, 1);
`else
    xfer("wrap_wr", 1'b1, 1'b0, 16'h0105, 16'h0077, 1'b0, 1'b0, 16'h0000, ea);
    chk("err_tied_low", {31'd0, ea}, 0);
    xfer("wrap_rd", 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0077, ea);
    chk("err_still_low", {31'd0, err}, 0);
`endif

    xfer("wr_9_prior", 1'b1, 1'b0, 16'h0009, 16'h0BAD, 1'b0, 1'b0, 16'h0000, ea);
    mem_write = 1'b1;
    addr      = 16'h0009;
    bus_in    = 16'hCAFE;
    tick();
    mem_write = 1'b0;
    chk("midwr_busy", {31'd0, busy}, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {12'd0, busy, done, bus_oe, err, bus_out}, 0);
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    rst = 1'b1;
    for (int k = 0; k < WS + 4; k++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    chk("midwr_no_done", dcnt, 0);
    xfer("rd_9_prior", 1'b0, 1'b1, 16'h0009, 16'h0000, 1'b0, 1'b1, 16'h0BAD, ea);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
